// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x3 matrix keypad front end. Drives one row low per scan
// tick, samples the synchronized column lines, debounces a single key press
// and its release, and reports the encoded key (0-9 binary, # = 1010,
// * = 1011) together with a key-held level.
module keypad_scanner #(
    parameter int SCAN_DIV   = 1000,  // clocks per row dwell, >= 4
    parameter int DEBOUNCE_N = 4      // matching ticks to accept press/release, >= 2
) (
    input  logic       clk,
    input  logic       reset_1,      // asynchronous, active-low
    input  logic [2:0] Col,          // active-low column sense, asynchronous
    output logic [3:0] Row,          // active-low row drive, one bit low
    output logic [3:0] Code_1,       // code of the last accepted key
    output logic       Valid_1,      // high while an accepted key is held
    output logic       S_Row,        // debounced key-held flag, same as Valid_1
    output logic [1:0] o_dbg_state   // current FSM state, for observation
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_N + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DCNT_MAX  = DW'(DEBOUNCE_N);

    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    logic [2:0]    r_col_meta;
    logic [2:0]    r_col_sync;
    logic [TW-1:0] r_tick_cnt;
    state_t        r_state;
    logic [DW-1:0] r_dcnt;
    logic [3:0]    r_row;
    logic [2:0]    r_cand;
    logic [3:0]    r_code;
    logic          r_valid;

    state_t        w_next_state;
    logic [DW-1:0] w_next_dcnt;
    logic [3:0]    w_next_row;
    logic [2:0]    w_next_cand;
    logic [3:0]    w_next_code;
    logic          w_next_valid;

    logic          w_tick;
    logic [2:0]    w_cs;
    logic          w_cs_idle;
    logic          w_cs_one_low;
    logic [3:0]    w_row_rot;
    logic [DW-1:0] w_dcnt_inc;
    logic          w_dcnt_done;
    logic [1:0]    w_row_idx;
    logic [1:0]    w_col_idx;
    logic [3:0]    w_key_code;

    assign w_tick       = (r_tick_cnt == TICK_LAST);
    assign w_cs         = r_col_sync;
    assign w_cs_idle    = (w_cs == 3'b111);
    assign w_cs_one_low = (w_cs == 3'b110) || (w_cs == 3'b101) || (w_cs == 3'b011);
    assign w_row_rot    = {r_row[2:0], r_row[3]};
    // dcnt saturates at DEBOUNCE_N so it can never wrap
    assign w_dcnt_inc   = (r_dcnt == DCNT_MAX) ? r_dcnt : r_dcnt + DW'(1);
    assign w_dcnt_done  = (w_dcnt_inc == DCNT_MAX);

    assign Row         = r_row;
    assign Code_1      = r_code;
    assign Valid_1     = r_valid;
    assign S_Row       = r_valid;
    assign o_dbg_state = r_state;

    // Two-flop synchronizer for the asynchronous column lines
    always_ff @(posedge clk or negedge reset_1) begin
        if (!reset_1) begin
            r_col_meta <= 3'b111;
            r_col_sync <= 3'b111;
        end else begin
            r_col_meta <= Col;
            r_col_sync <= r_col_meta;
        end
    end

    // Free-running scan tick divider, wraps silently
    always_ff @(posedge clk or negedge reset_1) begin
        if (!reset_1) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    // Row index of the frozen row and column index of the candidate
    always_comb begin
        w_row_idx = 2'd0;
        w_col_idx = 2'd0;
        case (r_row)
            4'b1101: w_row_idx = 2'd1;
            4'b1011: w_row_idx = 2'd2;
            4'b0111: w_row_idx = 2'd3;
            default: w_row_idx = 2'd0;
        endcase
        case (r_cand)
            3'b101:  w_col_idx = 2'd1;
            3'b011:  w_col_idx = 2'd2;
            default: w_col_idx = 2'd0;
        endcase
    end

    // Key encoding: rows 0..2 hold digits 1..9, row 3 holds *, 0, #
    always_comb begin
        w_key_code = 4'd0;
        if (w_row_idx == 2'd3) begin
            case (w_col_idx)
                2'd0:    w_key_code = 4'b1011;
                2'd1:    w_key_code = 4'b0000;
                default: w_key_code = 4'b1010;
            endcase
        end else begin
            w_key_code = ({2'b00, w_row_idx} * 4'd3) + {2'b00, w_col_idx} + 4'd1;
        end
    end

    // FSM state and output registers
    always_ff @(posedge clk or negedge reset_1) begin
        if (!reset_1) begin
            r_state <= ST_SCAN;
            r_dcnt  <= '0;
            r_row   <= 4'b1110;
            r_cand  <= 3'b111;
            r_code  <= 4'b0000;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_dcnt  <= w_next_dcnt;
            r_row   <= w_next_row;
            r_cand  <= w_next_cand;
            r_code  <= w_next_code;
            r_valid <= w_next_valid;
        end
    end

    // FSM next-state: everything advances only on a scan tick
    always_comb begin
        w_next_state = r_state;
        w_next_dcnt  = r_dcnt;
        w_next_row   = r_row;
        w_next_cand  = r_cand;
        w_next_code  = r_code;
        w_next_valid = r_valid;
        if (w_tick) begin
            case (r_state)
                ST_SCAN: begin
                    if (w_cs_one_low) begin
                        // freeze the row and start debouncing this key
                        w_next_cand  = w_cs;
                        w_next_dcnt  = DW'(1);
                        w_next_state = ST_CONFIRM;
                    end else begin
                        // idle or ghost/multi-key: keep scanning
                        w_next_row = w_row_rot;
                    end
                end
                ST_CONFIRM: begin
                    if (w_cs == r_cand) begin
                        if (w_dcnt_done) begin
                            w_next_code  = w_key_code;
                            w_next_valid = 1'b1;
                            w_next_dcnt  = '0;
                            w_next_state = ST_HELD;
                        end else begin
                            w_next_dcnt = w_dcnt_inc;
                        end
                    end else begin
                        w_next_dcnt  = '0;
                        w_next_row   = w_row_rot;
                        w_next_state = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    // any low column, whichever key, counts as still held
                    if (w_cs_idle) begin
                        if (w_dcnt_done) begin
                            w_next_valid = 1'b0;
                            w_next_dcnt  = '0;
                            w_next_row   = w_row_rot;
                            w_next_state = ST_SCAN;
                        end else begin
                            w_next_dcnt = w_dcnt_inc;
                        end
                    end else begin
                        w_next_dcnt = '0;
                    end
                end
                default: begin
                    w_next_dcnt  = '0;
                    w_next_state = ST_SCAN;
                end
            endcase
        end
    end

endmodule
